// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared function-select codes, skid-buffer states and flag bit
//               positions for the shifter writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Shift-left class
    localparam logic [3:0] FS_BSL      = 4'b1111;
    localparam logic [3:0] FS_BSL_ALT  = 4'b0010;
    // Shift-right class
    localparam logic [3:0] FS_BSR      = 4'b1101;
    localparam logic [3:0] FS_BSR_ALT0 = 4'b0100;
    localparam logic [3:0] FS_BSR_ALT1 = 4'b0110;
    // Rotate-right class
    localparam logic [3:0] FS_BRR      = 4'b1100;
    localparam logic [3:0] FS_BRR_ALT  = 4'b1010;
    // Rotate-left class
    localparam logic [3:0] FS_BRL      = 4'b1110;
    localparam logic [3:0] FS_BRL_ALT  = 4'b1000;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_carry.sv
`default_nettype none
// ============================================================================
// Module      : shift_carry
// Description : Combinational carry-out of the barrel shifter, derived from the
//               pre-shift operand or the result depending on the fs class.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_carry
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_operand,
    input  logic [WIDTH-1:0] i_result,
    input  logic [3:0]       i_fs,
    input  logic [3:0]       i_amt,
    output logic             o_carry
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] w_sl_idx;
    logic [IDX_W-1:0] w_sr_idx;

    // Both indices wrap harmlessly when i_amt is zero; that case forces C low.
    assign w_sl_idx = IDX_W'(WIDTH - int'(i_amt));
    assign w_sr_idx = IDX_W'(int'(i_amt) - 1);

    always_comb begin
        o_carry = 1'b0;
        if (i_amt != 4'd0) begin
            case (i_fs)
                FS_BSL, FS_BSL_ALT:              o_carry = i_operand[w_sl_idx];
                FS_BSR, FS_BSR_ALT0, FS_BSR_ALT1: o_carry = i_operand[w_sr_idx];
                FS_BRR, FS_BRR_ALT:              o_carry = i_result[WIDTH-1];
                FS_BRL, FS_BRL_ALT:              o_carry = i_result[0];
                default:                         o_carry = 1'b0;
            endcase
        end
    end

endmodule : shift_carry
`default_nettype wire

// File: rtl/shift_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_wb_stage
// Description : Two-entry skid buffer capturing shifter results (plus optional
//               Z/N/C flags, enabled by SHIFT_WB_FLAGS_EN) for writeback.
//               WIDTH must be >= 16 and a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_wb_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_result,
    input  logic [WIDTH-1:0] i_operand,
    input  logic [3:0]       i_fs,
    input  logic [3:0]       i_amt,
    input  logic [3:0]       i_dst,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_dst,
    output logic [2:0]       o_flags,
    output logic [CNT_W-1:0] o_count
);

    skid_state_e      state_q, state_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] head_result_q, head_result_d;
    logic [WIDTH-1:0] skid_result_q, skid_result_d;
    logic [3:0]       head_dst_q, head_dst_d;
    logic [3:0]       skid_dst_q, skid_dst_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic w_accept;
    logic w_deliver;
    logic w_load_head;
    logic w_load_skid;
    logic w_pop_skid;

    assign w_accept  = i_valid && ready_q;
    assign w_deliver = (state_q != EMPTY) && i_ready;

    always_comb begin
        state_d     = state_q;
        w_load_head = 1'b0;
        w_load_skid = 1'b0;
        w_pop_skid  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (w_accept) begin
                    state_d     = ONE;
                    w_load_head = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_deliver) begin
                    w_load_head = 1'b1;
                end else if (w_accept) begin
                    state_d     = FULL;
                    w_load_skid = 1'b1;
                end else if (w_deliver) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (w_deliver) begin
                    state_d    = ONE;
                    w_pop_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // o_ready is a flop so the upstream never sees a path from i_ready.
    assign ready_d = (state_d != FULL);

    always_comb begin
        head_result_d = head_result_q;
        head_dst_d    = head_dst_q;
        skid_result_d = skid_result_q;
        skid_dst_d    = skid_dst_q;
        if (w_load_head) begin
            head_result_d = i_result;
            head_dst_d    = i_dst;
        end else if (w_pop_skid) begin
            head_result_d = skid_result_q;
            head_dst_d    = skid_dst_q;
        end
        if (w_load_skid) begin
            skid_result_d = i_result;
            skid_dst_d    = i_dst;
        end
    end

    always_comb begin
        count_d = count_q;
        if (w_deliver && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= EMPTY;
            ready_q       <= 1'b1;
            head_result_q <= '0;
            head_dst_q    <= '0;
            skid_result_q <= '0;
            skid_dst_q    <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            head_result_q <= head_result_d;
            head_dst_q    <= head_dst_d;
            skid_result_q <= skid_result_d;
            skid_dst_q    <= skid_dst_d;
            count_q       <= count_d;
        end
    end

`ifdef SHIFT_WB_FLAGS_EN
    logic       w_carry;
    logic [2:0] w_in_flags;
    logic [2:0] head_flags_q, head_flags_d;
    logic [2:0] skid_flags_q, skid_flags_d;

    shift_carry #(
        .WIDTH (WIDTH)
    ) u_carry (
        .i_operand (i_operand),
        .i_result  (i_result),
        .i_fs      (i_fs),
        .i_amt     (i_amt),
        .o_carry   (w_carry)
    );

    always_comb begin
        w_in_flags         = '0;
        w_in_flags[FLAG_Z] = (i_result == '0);
        w_in_flags[FLAG_N] = i_result[WIDTH-1];
        w_in_flags[FLAG_C] = w_carry;
    end

    // Flags ride alongside the data using the same load/pop strobes.
    always_comb begin
        head_flags_d = head_flags_q;
        skid_flags_d = skid_flags_q;
        if (w_load_head) begin
            head_flags_d = w_in_flags;
        end else if (w_pop_skid) begin
            head_flags_d = skid_flags_q;
        end
        if (w_load_skid) begin
            skid_flags_d = w_in_flags;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_flags_q <= '0;
            skid_flags_q <= '0;
        end else begin
            head_flags_q <= head_flags_d;
            skid_flags_q <= skid_flags_d;
        end
    end

    assign o_flags = head_flags_q;
`else
    logic w_unused_flag_inputs;
    assign w_unused_flag_inputs = ^{i_operand, i_amt};
    assign o_flags              = 3'b000;
`endif

    assign o_valid  = (state_q != EMPTY);
    assign o_ready  = ready_q;
    assign o_result = head_result_q;
    assign o_dst    = head_dst_q;
    assign o_count  = count_q;

endmodule : shift_wb_stage
`default_nettype wire

// File: tb/tb_shift_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_wb_stage
// Description : Self-checking bench: queue-based reference model compared
//               every cycle, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        ready_in = 1'b0;
    logic [31:0] result = '0;
    logic [31:0] operand = '0;
    logic [3:0]  fs = '0;
    logic [3:0]  amt = '0;
    logic [3:0]  dst = '0;

    logic        o_ready, o_valid;
    logic [31:0] o_result;
    logic [3:0]  o_dst;
    logic [2:0]  o_flags;
    logic [15:0] o_count;

    logic        s_ready, s_valid;
    logic [31:0] s_result;
    logic [3:0]  s_dst;
    logic [2:0]  s_flags;
    logic [3:0]  s_count;

    always #5 clk = ~clk;

    shift_wb_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
        .i_result(result), .i_operand(operand), .i_fs(fs), .i_amt(amt),
        .i_dst(dst), .o_valid(o_valid), .i_ready(ready_in), .o_result(o_result),
        .o_dst(o_dst), .o_flags(o_flags), .o_count(o_count)
    );

    shift_wb_stage #(.WIDTH(32), .CNT_W(4)) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(s_ready),
        .i_result(result), .i_operand(operand), .i_fs(fs), .i_amt(amt),
        .i_dst(dst), .o_valid(s_valid), .i_ready(ready_in), .o_result(s_result),
        .o_dst(s_dst), .o_flags(s_flags), .o_count(s_count)
    );

    typedef struct {
        logic [31:0] r;
        logic [3:0]  d;
        logic [2:0]  f;
    } ent_t;

    ent_t mq[$];
    int   mcount = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   run_cmp = 1'b0;
    bit   bulk_on = 1'b0;
    int   bulk_cnt = 0;

    localparam logic [2:0] EXP_Z_ONLY = `ifdef SHIFT_WB_FLAGS_EN 3'b001 `else 3'b000 `endif;
    localparam logic [2:0] EXP_C_ONLY = `ifdef SHIFT_WB_FLAGS_EN 3'b100 `else 3'b000 `endif;
    localparam logic [2:0] EXP_C_Z    = `ifdef SHIFT_WB_FLAGS_EN 3'b101 `else 3'b000 `endif;

    // {C,N,Z} straight from the arithmetic definition of each fs class.
    function automatic logic [2:0] model_flags(input logic [31:0] res, input logic [31:0] op,
                                               input logic [3:0] f, input logic [3:0] a);
        logic c;
        int   n;
        c = 1'b0;
        n = int'(a);
`ifdef SHIFT_WB_FLAGS_EN
        if (n != 0) begin
            case (f)
                4'b1111, 4'b0010:          c = ((op >> (32 - n)) & 32'd1) != 0;
                4'b1101, 4'b0100, 4'b0110: c = ((op >> (n - 1)) & 32'd1) != 0;
                4'b1100, 4'b1010:          c = res[31];
                4'b1110, 4'b1000:          c = res[0];
                default:                   c = 1'b0;
            endcase
        end
        return {c, res[31], (res == 32'd0)};
`else
        return 3'b000 & {c, res[31], 1'b0} & 3'b000;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mcount = 0;
        end else begin
            bit   acc, del;
            ent_t e;
            acc = valid && (mq.size() < 2);
            del = (mq.size() > 0) && ready_in;
            if (del) begin
                void'(mq.pop_front());
                mcount++;
            end
            if (acc) begin
                e.r = result;
                e.d = dst;
                e.f = model_flags(result, operand, fs, amt);
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && run_cmp) begin
            chk("valid", {63'd0, o_valid}, {63'd0, mq.size() > 0});
            chk("ready", {63'd0, o_ready}, {63'd0, mq.size() < 2});
            chk("count", 64'(o_count), 64'(mcount > 65535 ? 65535 : mcount));
            chk("count_sat4", 64'(s_count), 64'(mcount > 15 ? 15 : mcount));
            if (mq.size() > 0) begin
                chk("result", 64'(o_result), 64'(mq[0].r));
                chk("dst", 64'(o_dst), 64'(mq[0].d));
                chk("flags", 64'(o_flags), 64'(mq[0].f));
            end
            if (bulk_on && o_valid && ready_in) bulk_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [31:0] r, input logic [31:0] op,
                        input logic [3:0] f, input logic [3:0] a, input logic [3:0] d);
        valid = 1'b1; result = r; operand = op; fs = f; amt = a; dst = d;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_valid_drop", {63'd0, o_valid}, 64'd0);
        chk("async_ready_high", {63'd0, o_ready}, 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_result", 64'(o_result), 64'd0);
        chk("rst_dst", 64'(o_dst), 64'd0);
        chk("rst_flags", 64'(o_flags), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        run_cmp = 1'b1;

        // Single zero result, pass-through fs
        push(32'h0, 32'h1234, 4'b0000, 4'd3, 4'd3);
        tick();
        valid = 1'b0;
        chk("single_valid", {63'd0, o_valid}, 64'd1);
        chk("single_flags", 64'(o_flags), 64'(EXP_Z_ONLY));
        ready_in = 1'b1;
        tick();
        chk("single_count", 64'(o_count), 64'd1);
        ready_in = 1'b0;

        // Shift-left carry
        push(32'h0000_0002, 32'h8000_0001, 4'b1111, 4'd1, 4'd5);
        tick();
        valid = 1'b0;
        chk("sl_flags", 64'(o_flags), 64'(EXP_C_ONLY));
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;

        // Shift-right carry with zero result
        push(32'h0, 32'h0000_0001, 4'b1101, 4'd1, 4'd6);
        tick();
        valid = 1'b0;
        chk("sr_flags", 64'(o_flags), 64'(EXP_C_Z));
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;

        // Three back-to-back with writeback stalled
        push(32'hAAAA_0001, 32'h0, 4'b0000, 4'd0, 4'd1);
        tick();
        chk("stall_ready1", {63'd0, o_ready}, 64'd1);
        push(32'hBBBB_0002, 32'h0, 4'b0000, 4'd0, 4'd2);
        tick();
        chk("stall_ready2", {63'd0, o_ready}, 64'd0);
        push(32'hCCCC_0003, 32'h0, 4'b0000, 4'd0, 4'd3);
        tick();
        chk("stall_ready3", {63'd0, o_ready}, 64'd0);
        chk("stall_head_a", 64'(o_result), 64'h0000_0000_AAAA_0001);
        ready_in = 1'b1;
        tick();
        chk("unstall_ready", {63'd0, o_ready}, 64'd1);
        chk("unstall_head_b", 64'(o_result), 64'h0000_0000_BBBB_0002);
        tick();
        valid = 1'b0;
        chk("unstall_head_c", 64'(o_result), 64'h0000_0000_CCCC_0003);
        tick();
        ready_in = 1'b0;

        // 100 results at full throughput from a fresh count
        async_reset();
        ready_in = 1'b1;
        bulk_cnt = 0;
        bulk_on = 1'b1;
        for (int k = 0; k < 100; k++) begin
            push(32'h1000_0000 + 32'(k), 32'(k), 4'b0000, 4'd0, 4'(k));
            tick();
        end
        valid = 1'b0;
        tick();
        bulk_on = 1'b0;
        chk("bulk_deliveries", 64'(bulk_cnt), 64'd100);
        chk("bulk_count", 64'(o_count), 64'd100);
        chk("bulk_count_sat4", 64'(s_count), 64'hF);
        ready_in = 1'b0;

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            valid    = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 2) != 0);
            result   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            operand  = $urandom;
            fs       = 4'($urandom_range(0, 15));
            amt      = 4'($urandom_range(0, 15));
            dst      = 4'($urandom_range(0, 15));
            tick();
        end

        // Fill, then reset while FULL
        valid = 1'b0;
        ready_in = 1'b1;
        repeat (3) tick();
        ready_in = 1'b0;
        push(32'h5555_0001, 32'h0, 4'b0000, 4'd0, 4'd9);
        tick();
        push(32'h5555_0002, 32'h0, 4'b0000, 4'd0, 4'd10);
        tick();
        valid = 1'b0;
        chk("full_ready_low", {63'd0, o_ready}, 64'd0);
        async_reset();
        tick();
        chk("post_rst_ready", {63'd0, o_ready}, 64'd1);
        chk("post_rst_count", 64'(o_count), 64'd0);
        chk("post_rst_valid", {63'd0, o_valid}, 64'd0);

        repeat (2) tick();
        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_wb_stage
`default_nettype wire
